// File: rtl/re_camera_ctrl.sv
// re_camera_ctrl: exposure/readout controller for the rolling-electronic pixel array.
// Optional macro CAM_CDS_EN selects correlated double sampling (5-cycle row slot).
module re_camera_ctrl #(
    parameter int ROWS    = 2,
    parameter int EXP_W   = 5,
    parameter int EXP_MIN = 2,
    parameter int EXP_MAX = 30,
    parameter int EXP_DEF = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             cont,
    input  logic             exp_incr,
    input  logic             exp_decr,
    output logic [ROWS-1:0]  NRE,
    output logic             expose,
    output logic             erase,
    output logic             adc,
    output logic             busy,
    output logic             frame_done,
    output logic [EXP_W-1:0] exp_time
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef CAM_CDS_EN
    localparam int                SLOT_W    = 3;
    localparam logic [SLOT_W-1:0] SLOT_LAST = 3'd4;
`else
    localparam int                SLOT_W    = 2;
    localparam logic [SLOT_W-1:0] SLOT_LAST = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, EXPOSE, READ} state_t;

    state_t            state;
    logic [EXP_W-1:0]  exp_cnt;
    logic [ROW_W-1:0]  row;
    logic [SLOT_W-1:0] slot;
    logic [EXP_W-1:0]  exp_next;
    logic [SLOT_W-1:0] slot_next;
    logic              adc_next;

    always_comb begin
        exp_next = exp_time;
        if (exp_incr && !exp_decr && exp_time < EXP_W'(EXP_MAX))
            exp_next = exp_time + EXP_W'(1);
        else if (exp_decr && !exp_incr && exp_time > EXP_W'(EXP_MIN))
            exp_next = exp_time - EXP_W'(1);
    end

    // adc is registered, so it is decoded from the slot being entered
    always_comb begin
        slot_next = slot + SLOT_W'(1);
`ifdef CAM_CDS_EN
        adc_next  = (slot_next == 3'd1) || (slot_next == 3'd3);
`else
        adc_next  = (slot_next == 2'd1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            erase      <= 1'b1;
            expose     <= 1'b0;
            NRE        <= '1;
            adc        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            exp_time   <= EXP_W'(EXP_DEF);
            exp_cnt    <= '0;
            row        <= '0;
            slot       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    exp_time <= exp_next;
                    if (init || cont) begin
                        state   <= EXPOSE;
                        erase   <= 1'b0;
                        expose  <= 1'b1;
                        busy    <= 1'b1;
                        exp_cnt <= '0;
                    end
                end
                EXPOSE: begin
                    if (exp_cnt == exp_time - EXP_W'(1)) begin
                        state  <= READ;
                        expose <= 1'b0;
                        row    <= '0;
                        slot   <= '0;
                        NRE    <= ~ROWS'(1);
                    end else begin
                        exp_cnt <= exp_cnt + EXP_W'(1);
                    end
                end
                READ: begin
                    if (slot == SLOT_LAST) begin
                        slot <= '0;
                        if (row == ROW_W'(ROWS - 1)) begin
                            state      <= IDLE;
                            erase      <= 1'b1;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            row <= row + ROW_W'(1);
                            NRE <= ~(ROWS'(1) << (row + ROW_W'(1)));
                        end
                    end else begin
                        slot <= slot_next;
                        adc  <= adc_next;
                        if (slot_next == SLOT_LAST)
                            NRE <= '1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_re_camera_ctrl.sv
// Scoreboard bench for re_camera_ctrl: per-cycle expected output vectors keyed by cycle number.
module tb_re_camera_ctrl;
    localparam int ROWS    = 2;
    localparam int EXP_W   = 5;
    localparam int EXP_MIN = 2;
    localparam int EXP_MAX = 30;
    localparam int EXP_DEF = 4;
`ifdef CAM_CDS_EN
    localparam int SLOT = 5;
`else
    localparam int SLOT = 3;
`endif

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             init     = 1'b0;
    logic             cont     = 1'b0;
    logic             exp_incr = 1'b0;
    logic             exp_decr = 1'b0;
    logic [ROWS-1:0]  NRE;
    logic             expose, erase, adc, busy, frame_done;
    logic [EXP_W-1:0] exp_time;

    re_camera_ctrl #(
        .ROWS(ROWS), .EXP_W(EXP_W), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX), .EXP_DEF(EXP_DEF)
    ) dut (
        .clk(clk), .reset(reset), .init(init), .cont(cont),
        .exp_incr(exp_incr), .exp_decr(exp_decr),
        .NRE(NRE), .expose(expose), .erase(erase), .adc(adc),
        .busy(busy), .frame_done(frame_done), .exp_time(exp_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] v;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t cur;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int et_m   = EXP_DEF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] pack(input logic [ROWS-1:0] n, input logic ex, input logic er,
                                         input logic ad, input logic bs, input logic fd,
                                         input logic [EXP_W-1:0] et);
        logic [31:0] r;
        r = '0;
        r[EXP_W-1:0]       = et;
        r[EXP_W]           = fd;
        r[EXP_W+1]         = bs;
        r[EXP_W+2]         = ad;
        r[EXP_W+3]         = er;
        r[EXP_W+4]         = ex;
        r[EXP_W+5 +: ROWS] = n;
        return r;
    endfunction

    function automatic logic [31:0] idle_v(input logic fd, input int et);
        return pack('1, 1'b0, 1'b1, 1'b0, 1'b0, fd, EXP_W'(et));
    endfunction

    function automatic int next_et(input int et, input bit inc, input bit dec);
        if (inc && !dec && et < EXP_MAX) return et + 1;
        if (dec && !inc && et > EXP_MIN) return et - 1;
        return et;
    endfunction

    // Compared at each negedge whose cycle count matches
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            check_val(cur.tag, pack(NRE, expose, erase, adc, busy, frame_done, exp_time), cur.v);
        end
    end

    task automatic sb_push(input int c, input string tag, input logic [31:0] v);
        sb_entry_t e;
        e.cyc = c;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic push_frame(input int s, input int et);
        logic [ROWS-1:0] n;
        for (int i = 0; i < et; i++)
            sb_push(s + i, "expose", pack('1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, EXP_W'(et)));
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < SLOT; k++) begin
                n = '1;
                if (k < SLOT - 1) n[r] = 1'b0;
                sb_push(s + et + r * SLOT + k, "read",
                        pack(n, 1'b0, 1'b0, (k == 1) || (SLOT == 5 && k == 3), 1'b1, 1'b0, EXP_W'(et)));
            end
        end
        sb_push(s + et + ROWS * SLOT, "done", idle_v(1'b1, et));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step_idle(input bit inc, input bit dec);
        init     = 1'b0;
        cont     = 1'b0;
        exp_incr = inc;
        exp_decr = dec;
        et_m = next_et(et_m, inc, dec);
        sb_push(cyc + 1, "idle", idle_v(1'b0, et_m));
        tick();
    endtask

    // Increment held during reset must not leak into exp_time
    task automatic do_reset();
        sb.delete();
        reset    = 1'b0;
        init     = 1'b0;
        cont     = 1'b0;
        exp_incr = 1'b1;
        exp_decr = 1'b0;
        et_m     = EXP_DEF;
        sb_push(cyc + 1, "reset", idle_v(1'b0, EXP_DEF));
        tick();
        reset    = 1'b1;
        exp_incr = 1'b0;
    endtask

    task automatic frame(input bit use_cont, input bit inc, input bit inc_during,
                         input int keep_cont, input int abort_at);
        int busy_n;
        init     = !use_cont;
        cont     = use_cont;
        exp_incr = inc;
        exp_decr = 1'b0;
        et_m = next_et(et_m, inc, 1'b0);
        push_frame(cyc + 1, et_m);
        busy_n = et_m + SLOT * ROWS;
        tick();
        init     = 1'b0;
        exp_incr = inc_during;
        for (int i = 0; i < busy_n; i++) begin
            if (i >= keep_cont) cont = 1'b0;
            if (i == abort_at) begin
                do_reset();
                return;
            end
            tick();
        end
        exp_incr = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        repeat (2) step_idle(0, 0);
        repeat (3) step_idle(1, 0);
        do_reset();

        repeat (10) step_idle(1, 0);
        repeat (30) step_idle(1, 0);
        repeat (40) step_idle(0, 1);
        repeat (5)  step_idle(1, 1);
        repeat (2)  step_idle(1, 0);

        frame(0, 0, 0, 0, -1);
        repeat (2) step_idle(0, 0);

        frame(0, 0, 1, 0, -1);
        repeat (2) step_idle(0, 0);

        frame(0, 1, 0, 0, -1);
        step_idle(0, 1);

        frame(1, 0, 0, 1000, -1);
        frame(1, 0, 0, 1000, -1);
        frame(1, 0, 0, et_m + SLOT + 1, -1);
        repeat (5) step_idle(0, 0);

        frame(0, 0, 0, 0, et_m + SLOT + 1);
        repeat (3) step_idle(0, 0);

        tick();
        tick();
        check_val("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
